// File: rtl/ppu_vram_port_pkg.sv
// Shared PPU definitions: VRAM port FSM states and the address increment steps.
package ppu_vram_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND_WR,
        ST_PEND_RD,
        ST_RD_CAPT
    } vram_state_t;

    localparam logic [13:0] INC1  = 14'd1;
    localparam logic [13:0] INC32 = 14'd32;

    function automatic logic [13:0] vram_step(input logic [13:0] addr,
                                              input logic        sel32,
                                              input logic [13:0] wrap);
        return (addr + (sel32 ? INC32 : INC1)) & wrap;
    endfunction

endpackage

// File: rtl/ppu_vram_port.sv
// PPU VRAM bus arbiter: CPU PPUADDR/PPUDATA access (buffered reads) sharing
// the single memory port with render fetches.
module ppu_vram_port
    import ppu_vram_port_pkg::*;
#(
    parameter logic [13:0] INC_WRAP = 14'h3FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rendering,
    input  logic        rend_req,
    input  logic [13:0] rend_addr,
    output logic        rend_valid,
    output logic [7:0]  rend_q,
    input  logic        cpu_wr_addr,
    input  logic        cpu_wr_data,
    input  logic        cpu_rd_data,
    input  logic        cpu_rd_status,
    input  logic        inc32,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_busy,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_rw,
    input  logic [7:0]  mem_q
);

    vram_state_t state;
    logic [13:0] v;
    logic        w;
    logic [7:0]  hold;

    logic        cpu_pend;
    logic        cpu_issue;
    logic        rend_grant;
    logic [13:0] v_nxt;
    logic        w_nxt;

    // Reset gates the bus decisions so the port presents all-zero outputs
    // while rst_n is low, even with a render request asserted.
    assign cpu_pend   = (state == ST_PEND_WR) || (state == ST_PEND_RD);
    assign cpu_issue  = rst_n && cpu_pend && !(rendering && rend_req);
    assign rend_grant = rst_n && rend_req && (rendering || !cpu_issue);

    assign mem_addr = rend_grant ? rend_addr : v;
    assign mem_rw   = cpu_issue && (state == ST_PEND_WR);
    assign mem_data = hold;
    assign cpu_busy = (state != ST_IDLE);
    assign rend_q   = rend_valid ? mem_q : '0;

    // Post-increment first, then any PPUADDR byte write, then status clears w.
    always_comb begin
        v_nxt = v;
        w_nxt = w;
        if (cpu_issue) begin
            v_nxt = vram_step(v, inc32, INC_WRAP);
        end
        if (cpu_wr_addr) begin
            if (!w) begin
                v_nxt[13:8] = cpu_din[5:0];
                w_nxt       = 1'b1;
            end else begin
                v_nxt[7:0] = cpu_din;
                w_nxt      = 1'b0;
            end
        end
        if (cpu_rd_status) begin
            w_nxt = 1'b0;
        end
        v_nxt = v_nxt & INC_WRAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            v          <= '0;
            w          <= 1'b0;
            hold       <= '0;
            cpu_dout   <= '0;
            rend_valid <= 1'b0;
        end else begin
            v          <= v_nxt;
            w          <= w_nxt;
            rend_valid <= rend_grant;
            case (state)
                ST_IDLE: begin
                    if (cpu_wr_data) begin
                        hold  <= cpu_din;
                        state <= ST_PEND_WR;
                    end else if (cpu_rd_data) begin
                        state <= ST_PEND_RD;
                    end
                end
                ST_PEND_WR: begin
                    if (cpu_issue) begin
                        state <= ST_IDLE;
                    end
                end
                ST_PEND_RD: begin
                    if (cpu_issue) begin
                        state <= ST_RD_CAPT;
                    end
                end
                ST_RD_CAPT: begin
                    cpu_dout <= mem_q;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Self-checking bench for ppu_vram_port: directed scenarios plus randomized
// CPU/render traffic checked against an address/memory-image reference model.
module tb_ppu_vram_port;

    logic        clk;
    logic        rst_n;
    logic        rendering;
    logic        rend_req;
    logic [13:0] rend_addr;
    logic        rend_valid;
    logic [7:0]  rend_q;
    logic        cpu_wr_addr;
    logic        cpu_wr_data;
    logic        cpu_rd_data;
    logic        cpu_rd_status;
    logic        inc32;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_busy;
    logic [13:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_rw;
    logic [7:0]  mem_q;

    ppu_vram_port #(.INC_WRAP(14'h3FFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .rendering(rendering), .rend_req(rend_req), .rend_addr(rend_addr),
        .rend_valid(rend_valid), .rend_q(rend_q),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_rd_status(cpu_rd_status),
        .inc32(inc32), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: synchronous write, read data one cycle after address.
    logic [7:0] ram [0:16383];
    always @(posedge clk) begin
        if (mem_rw) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  ref_mem [0:16383];
    logic [13:0] m_v;
    logic [7:0]  m_dout;
    logic [21:0] wq[$];
    bit          noise;

    function automatic logic [13:0] next_addr(input logic [13:0] a, input logic big);
        return 14'((int'(a) + (big ? 32 : 1)) % 16384);
    endfunction

    // Render and write scoreboard, sampled at the inactive edge.
    bit          prev_ok;
    bit          prev_hold;
    bit          prev_req;
    logic [7:0]  prev_exp;
    logic [21:0] wexp;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rw) begin
                chk("write_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    wexp = wq.pop_front();
                    chk("write_addr_data", {mem_addr, mem_data}, wexp);
                end
            end
            if (prev_ok) begin
                if (prev_hold) chk("rend_valid_forced", rend_valid, 1);
                if (!prev_req) chk("rend_valid_noreq", rend_valid, 0);
                if (rend_valid) chk("rend_q", rend_q, prev_exp);
            end
            prev_ok   = 1;
            prev_hold = rendering && rend_req;
            prev_req  = rend_req;
            prev_exp  = ram[rend_addr];
        end else begin
            prev_ok = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (noise) begin
            rendering = 1'($urandom);
            rend_req  = 1'($urandom);
            rend_addr = 14'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu_busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", cpu_busy, 0);
    endtask

    task automatic check_v(input string tag, input logic [13:0] exp);
        rend_req = 1'b0;
        #1;
        chk(tag, mem_addr, exp);
    endtask

    task automatic set_addr(input logic [13:0] a);
        cpu_wr_addr = 1'b1;
        cpu_din     = {2'b00, a[13:8]};
        tick();
        cpu_din = a[7:0];
        tick();
        cpu_wr_addr = 1'b0;
        m_v = a;
    endtask

    task automatic wr_data(input logic [7:0] d);
        bit acc;
        acc = !cpu_busy;
        cpu_wr_data = 1'b1;
        cpu_din     = d;
        if (acc) begin
            wq.push_back({m_v, d});
            ref_mem[m_v] = d;
            m_v = next_addr(m_v, inc32);
        end
        tick();
        cpu_wr_data = 1'b0;
    endtask

    task automatic rd_data();
        bit acc;
        logic [13:0] ra;
        chk("dout_at_strobe", cpu_dout, m_dout);
        acc = !cpu_busy;
        cpu_rd_data = 1'b1;
        ra = m_v;
        if (acc) m_v = next_addr(m_v, inc32);
        tick();
        cpu_rd_data = 1'b0;
        if (acc) begin
            wait_idle();
            m_dout = ref_mem[ra];
            chk("dout_after_fetch", cpu_dout, m_dout);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [13:0] a;
        for (int i = 0; i < 16384; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        noise = 0;
        rst_n = 0;
        rendering = 0; rend_req = 0; rend_addr = '0;
        cpu_wr_addr = 0; cpu_wr_data = 0; cpu_rd_data = 0; cpu_rd_status = 0;
        inc32 = 0; cpu_din = '0;
        m_v = '0; m_dout = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", cpu_busy, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_dout", cpu_dout, 0);
        chk("rst_rend_valid", rend_valid, 0);
        chk("rst_rend_q", rend_q, 0);
        @(posedge clk);
        #1 rst_n = 1;
        tick();

        // Basic write at 2108, post-increment by one
        set_addr(14'h2108);
        wr_data(8'h5A);
        wait_idle();
        check_v("v_after_write", 14'h2109);

        // Buffered reads with +32 stepping
        inc32 = 1;
        set_addr(14'h23C0);
        rd_data();
        rd_data();
        check_v("v_after_reads", 14'h2400);

        // Wrap at top of address space, second strobe while busy is dropped
        inc32 = 0;
        set_addr(14'h3FFF);
        wr_data(8'hAA);
        wr_data(8'hBB);
        wait_idle();
        check_v("v_wrap_plus1", 14'h0000);
        inc32 = 1;
        set_addr(14'h3FF0);
        wr_data(8'h11);
        wait_idle();
        check_v("v_wrap_plus32", 14'h0010);
        inc32 = 0;

        // Status read clears the toggle between the two PPUADDR writes
        cpu_wr_addr = 1; cpu_din = 8'h3F; tick();
        cpu_wr_addr = 0; cpu_rd_status = 1; tick();
        cpu_rd_status = 0; cpu_wr_addr = 1; cpu_din = 8'h00; tick();
        cpu_wr_addr = 0;
        rend_req = 0;
        #1 chk("v_hi_after_status", mem_addr[13:8], 0);
        cpu_wr_addr = 1; cpu_din = 8'h55; tick();
        cpu_wr_addr = 0;
        check_v("v_toggle_cleared", 14'h0055);

        // Status coincident with a PPUADDR write: write first, then clear
        cpu_wr_addr = 1; cpu_rd_status = 1; cpu_din = 8'h15; tick();
        cpu_rd_status = 0; cpu_din = 8'h2A; tick();
        cpu_din = 8'h10; tick();
        cpu_wr_addr = 0;
        check_v("v_status_coincident", 14'h2A10);
        m_v = 14'h2A10;

        // Rendering owns the bus for 10 cycles; pending write issues after
        rendering = 1; rend_req = 0;
        wr_data(8'hC3);
        for (int k = 1; k <= 12; k++) begin
            rend_req  = (k <= 10);
            rend_addr = 14'($urandom);
            @(negedge clk);
            chk("hold_mem_rw", mem_rw, 32'(k == 11));
            chk("hold_rend_valid", rend_valid, 32'(k >= 2 && k <= 11));
            tick();
        end
        rendering = 0; rend_req = 0;
        wait_idle();

        // Not rendering: CPU issue beats a render request
        a = m_v;
        wr_data(8'h3C);
        rend_req = 1; rend_addr = 14'($urandom);
        @(negedge clk);
        chk("cpu_wins_rw", mem_rw, 1);
        chk("cpu_wins_addr", mem_addr, a);
        tick();
        rend_req = 0;
        @(negedge clk);
        chk("cpu_wins_no_valid", rend_valid, 0);
        tick();

        // PPUADDR rewrite while a write is blocked: issue uses the new v
        rendering = 1; rend_req = 1; rend_addr = 14'h0100;
        cpu_wr_data = 1; cpu_din = 8'h77; tick();
        cpu_wr_data = 0;
        set_addr(14'h1234);
        wq.push_back({14'h1234, 8'h77});
        ref_mem[14'h1234] = 8'h77;
        m_v = 14'h1235;
        rend_req = 0;
        tick();
        wait_idle();
        check_v("v_addr_while_busy", 14'h1235);

        // Reset during a blocked write abandons it
        rendering = 1; rend_req = 1;
        cpu_wr_data = 1; cpu_din = 8'hE7; tick();
        cpu_wr_data = 0;
        tick(); tick();
        chk("pend_busy", cpu_busy, 1);
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_busy", cpu_busy, 0);
        chk("mid_rst_mem_rw", mem_rw, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_data", mem_data, 0);
        chk("mid_rst_dout", cpu_dout, 0);
        chk("mid_rst_rend_valid", rend_valid, 0);
        chk("mid_rst_rend_q", rend_q, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        rendering = 0; rend_req = 0;
        m_v = '0; m_dout = '0;
        repeat (6) tick();
        chk("post_rst_busy", cpu_busy, 0);
        chk("post_rst_mem_data", mem_data, 0);
        check_v("post_rst_v", 14'h0000);

        // Randomized traffic against the reference model
        noise = 1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom % 4)
                0: set_addr(14'($urandom));
                1: begin
                    wr_data(8'($urandom));
                    if ($urandom % 3 == 0) wr_data(8'($urandom));
                    wait_idle();
                end
                2: rd_data();
                default: inc32 = 1'($urandom);
            endcase
        end
        noise = 0;
        rendering = 0; rend_req = 0;
        wait_idle();
        rd_data();
        repeat (3) tick();
        chk("writes_drained", wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
